// File: rtl/id_ex_fwd_stage_pkg.sv
// Shared widths and operand-A select encodings for the ID/EX forwarding stage.
package id_ex_fwd_stage_pkg;

  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;

  typedef enum logic [1:0] {
    ASEL_REG   = 2'b00,
    ASEL_PC    = 2'b01,
    ASEL_ALU   = 2'b10,
    ASEL_DATAD = 2'b11
  } asel_e;

endpackage

// File: rtl/id_ex_fwd_stage_fwd_sel_a.sv
// Operand select and load-use detection for one source register.
// Kept free of operand-A specifics so the operand-B path can reuse it.
module fwd_sel_a
  import id_ex_fwd_stage_pkg::*;
#(
  parameter int RADDR_W_P = RADDR_W
) (
  input  logic                 id_valid_i,
  input  logic [RADDR_W_P-1:0] rs_addr_i,
  input  logic                 use_pc_i,
  input  logic                 ex_valid_i,
  input  logic                 ex_we_i,
  input  logic [RADDR_W_P-1:0] ex_rd_i,
  input  logic                 ex_is_load_i,
  input  logic                 mem_we_i,
  input  logic [RADDR_W_P-1:0] mem_rd_i,
  output logic [1:0]           asel_o,
  output logic                 load_use_o
);

  logic hit_ex;
  logic hit_mem;

  always_comb begin
    hit_ex     = ex_valid_i && ex_we_i && (ex_rd_i != '0) && (ex_rd_i == rs_addr_i);
    hit_mem    = mem_we_i && (mem_rd_i != '0) && (mem_rd_i == rs_addr_i);
    load_use_o = id_valid_i && !use_pc_i && hit_ex && ex_is_load_i;

    // The younger producer in EX must win over the older one in MEM.
    if (use_pc_i)     asel_o = ASEL_PC;
    else if (hit_ex)  asel_o = ASEL_ALU;
    else if (hit_mem) asel_o = ASEL_DATAD;
    else              asel_o = ASEL_REG;
  end

endmodule

// File: rtl/id_ex_fwd_stage.sv
// ID/EX register for the operand-A path: captures the ID instruction, keeps a
// MEM-stage {rd, we} shadow and registers the forwarding select for EX.
module id_ex_fwd_stage
  import id_ex_fwd_stage_pkg::*;
#(
  parameter int XLEN_P    = XLEN,
  parameter int RADDR_W_P = RADDR_W
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 id_valid_i,
  input  logic [XLEN_P-1:0]    id_pc_i,
  input  logic [XLEN_P-1:0]    id_rs1_data_i,
  input  logic [RADDR_W_P-1:0] id_rs1_addr_i,
  input  logic                 id_use_pc_i,
  input  logic [RADDR_W_P-1:0] id_rd_addr_i,
  input  logic                 id_reg_we_i,
  input  logic                 id_is_load_i,
  input  logic                 flush_i,
  output logic                 id_ready_o,
  output logic                 ex_valid_o,
  output logic [XLEN_P-1:0]    ex_pc_o,
  output logic [XLEN_P-1:0]    ex_rs1_data_o,
  output logic [1:0]           ex_asel_o,
  output logic [RADDR_W_P-1:0] ex_rd_addr_o,
  output logic                 ex_reg_we_o,
  output logic                 ex_is_load_o
);

  logic                 ex_valid_q,   ex_valid_d;
  logic [XLEN_P-1:0]    ex_pc_q,      ex_pc_d;
  logic [XLEN_P-1:0]    ex_rs1_data_q, ex_rs1_data_d;
  logic [1:0]           ex_asel_q,    ex_asel_d;
  logic [RADDR_W_P-1:0] ex_rd_q,      ex_rd_d;
  logic                 ex_we_q,      ex_we_d;
  logic                 ex_load_q,    ex_load_d;
  logic [RADDR_W_P-1:0] mem_rd_q,     mem_rd_d;
  logic                 mem_we_q,     mem_we_d;

  logic [1:0] asel;
  logic       load_use;

  fwd_sel_a #(
    .RADDR_W_P (RADDR_W_P)
  ) u_fwd_sel_a (
    .id_valid_i   (id_valid_i),
    .rs_addr_i    (id_rs1_addr_i),
    .use_pc_i     (id_use_pc_i),
    .ex_valid_i   (ex_valid_q),
    .ex_we_i      (ex_we_q),
    .ex_rd_i      (ex_rd_q),
    .ex_is_load_i (ex_load_q),
    .mem_we_i     (mem_we_q),
    .mem_rd_i     (mem_rd_q),
    .asel_o       (asel),
    .load_use_o   (load_use)
  );

  always_comb begin
    ex_valid_d    = ex_valid_q;
    ex_pc_d       = ex_pc_q;
    ex_rs1_data_d = ex_rs1_data_q;
    ex_asel_d     = ex_asel_q;
    ex_rd_d       = ex_rd_q;
    ex_we_d       = ex_we_q;
    ex_load_d     = ex_load_q;
    // EX and MEM never stall, so the shadow slot simply follows EX.
    mem_rd_d      = ex_rd_q;
    mem_we_d      = ex_we_q;

    if (flush_i || load_use) begin
      // Bubble: pc/data/rd keep their old values, only the flags are cleared.
      ex_valid_d = 1'b0;
      ex_we_d    = 1'b0;
      ex_load_d  = 1'b0;
      ex_asel_d  = ASEL_REG;
    end else begin
      ex_valid_d    = id_valid_i;
      ex_pc_d       = id_pc_i;
      ex_rs1_data_d = id_rs1_data_i;
      ex_asel_d     = asel;
      ex_rd_d       = id_rd_addr_i;
      ex_we_d       = id_valid_i && id_reg_we_i;
      ex_load_d     = id_valid_i && id_is_load_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ex_valid_q    <= 1'b0;
      ex_pc_q       <= '0;
      ex_rs1_data_q <= '0;
      ex_asel_q     <= ASEL_REG;
      ex_rd_q       <= '0;
      ex_we_q       <= 1'b0;
      ex_load_q     <= 1'b0;
      mem_rd_q      <= '0;
      mem_we_q      <= 1'b0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_pc_q       <= ex_pc_d;
      ex_rs1_data_q <= ex_rs1_data_d;
      ex_asel_q     <= ex_asel_d;
      ex_rd_q       <= ex_rd_d;
      ex_we_q       <= ex_we_d;
      ex_load_q     <= ex_load_d;
      mem_rd_q      <= mem_rd_d;
      mem_we_q      <= mem_we_d;
    end
  end

  assign id_ready_o    = !load_use || flush_i;
  assign ex_valid_o    = ex_valid_q;
  assign ex_pc_o       = ex_pc_q;
  assign ex_rs1_data_o = ex_rs1_data_q;
  assign ex_asel_o     = ex_asel_q;
  assign ex_rd_addr_o  = ex_rd_q;
  assign ex_reg_we_o   = ex_we_q;
  assign ex_is_load_o  = ex_load_q;

endmodule

// File: tb/tb_id_ex_fwd_stage.sv
// Directed bench for id_ex_fwd_stage: forwarding selects, load-use stall, flush, reset.
module tb_id_ex_fwd_stage;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        id_valid_i;
  logic [31:0] id_pc_i;
  logic [31:0] id_rs1_data_i;
  logic [4:0]  id_rs1_addr_i;
  logic        id_use_pc_i;
  logic [4:0]  id_rd_addr_i;
  logic        id_reg_we_i;
  logic        id_is_load_i;
  logic        flush_i;
  logic        id_ready_o;
  logic        ex_valid_o;
  logic [31:0] ex_pc_o;
  logic [31:0] ex_rs1_data_o;
  logic [1:0]  ex_asel_o;
  logic [4:0]  ex_rd_addr_o;
  logic        ex_reg_we_o;
  logic        ex_is_load_o;

  int n_checks = 0;
  int n_errors = 0;

  id_ex_fwd_stage dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .id_valid_i    (id_valid_i),
    .id_pc_i       (id_pc_i),
    .id_rs1_data_i (id_rs1_data_i),
    .id_rs1_addr_i (id_rs1_addr_i),
    .id_use_pc_i   (id_use_pc_i),
    .id_rd_addr_i  (id_rd_addr_i),
    .id_reg_we_i   (id_reg_we_i),
    .id_is_load_i  (id_is_load_i),
    .flush_i       (flush_i),
    .id_ready_o    (id_ready_o),
    .ex_valid_o    (ex_valid_o),
    .ex_pc_o       (ex_pc_o),
    .ex_rs1_data_o (ex_rs1_data_o),
    .ex_asel_o     (ex_asel_o),
    .ex_rd_addr_o  (ex_rd_addr_o),
    .ex_reg_we_o   (ex_reg_we_o),
    .ex_is_load_o  (ex_is_load_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] data,
                       input logic [4:0] rs1, input logic use_pc, input logic [4:0] rd,
                       input logic we, input logic ld, input logic fl);
    id_valid_i    = v;
    id_pc_i       = pc;
    id_rs1_data_i = data;
    id_rs1_addr_i = rs1;
    id_use_pc_i   = use_pc;
    id_rd_addr_i  = rd;
    id_reg_we_i   = we;
    id_is_load_i  = ld;
    flush_i       = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"}, {31'd0, ex_valid_o},   32'd0);
    chk({tag, "_pc"},    ex_pc_o,               32'd0);
    chk({tag, "_data"},  ex_rs1_data_o,         32'd0);
    chk({tag, "_asel"},  {30'd0, ex_asel_o},    32'd0);
    chk({tag, "_rd"},    {27'd0, ex_rd_addr_o}, 32'd0);
    chk({tag, "_we"},    {31'd0, ex_reg_we_o},  32'd0);
    chk({tag, "_load"},  {31'd0, ex_is_load_o}, 32'd0);
    chk({tag, "_ready"}, {31'd0, id_ready_o},   32'd1);
  endtask

  initial begin
    rst_n_i = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    #3;
    chk_reset_state("rst_init");
    @(negedge clk_i);
    rst_n_i = 1'b1;
    #1;

    // addi x5,x1 then add x6,x5,x1 back-to-back -> EX forward
    drive(1'b1, 32'h100, 32'hAAAA_0001, 5'd1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    chk("addi_valid", {31'd0, ex_valid_o},   32'd1);
    chk("addi_pc",    ex_pc_o,               32'h100);
    chk("addi_data",  ex_rs1_data_o,         32'hAAAA_0001);
    chk("addi_asel",  {30'd0, ex_asel_o},    32'd0);
    chk("addi_rd",    {27'd0, ex_rd_addr_o}, 32'd5);
    chk("addi_we",    {31'd0, ex_reg_we_o},  32'd1);
    drive(1'b1, 32'h104, 32'hBBBB_0002, 5'd5, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
    chk("add_ex_ready", {31'd0, id_ready_o}, 32'd1);
    tick();
    chk("add_ex_asel",  {30'd0, ex_asel_o}, 32'd2);
    chk("add_ex_pc",    ex_pc_o,            32'h104);

    // addi x7; nop; add rs1=x7 -> MEM forward
    drive(1'b1, 32'h108, 32'h0, 5'd2, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
    tick();
    chk("addi7_asel", {30'd0, ex_asel_o}, 32'd0);
    drive(1'b1, 32'h10C, 32'h0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h110, 32'h0, 5'd7, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
    tick();
    chk("add_mem_asel", {30'd0, ex_asel_o}, 32'd3);

    // lw x5; add x6,x5 -> one-cycle stall, bubble, then DATAD
    drive(1'b1, 32'h200, 32'h0, 5'd3, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    tick();
    chk("lw_load", {31'd0, ex_is_load_o}, 32'd1);
    drive(1'b1, 32'h204, 32'h1234, 5'd5, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
    chk("lu_ready_low", {31'd0, id_ready_o}, 32'd0);
    tick();
    chk("lu_bubble_valid", {31'd0, ex_valid_o},   32'd0);
    chk("lu_bubble_we",    {31'd0, ex_reg_we_o},  32'd0);
    chk("lu_bubble_load",  {31'd0, ex_is_load_o}, 32'd0);
    chk("lu_bubble_asel",  {30'd0, ex_asel_o},    32'd0);
    chk("lu_bubble_pc",    ex_pc_o,               32'h200);
    chk("lu_ready_back",   {31'd0, id_ready_o},   32'd1);
    tick();
    chk("lu_add_valid", {31'd0, ex_valid_o}, 32'd1);
    chk("lu_add_asel",  {30'd0, ex_asel_o},  32'd3);
    chk("lu_add_pc",    ex_pc_o,             32'h204);
    chk("lu_add_data",  ex_rs1_data_o,       32'h1234);

    // lw x8; dependent add with flush in the stall cycle
    drive(1'b1, 32'h300, 32'h0, 5'd3, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'h304, 32'h0, 5'd8, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1);
    chk("fl_ready", {31'd0, id_ready_o}, 32'd1);
    tick();
    chk("fl_bubble_valid", {31'd0, ex_valid_o},  32'd0);
    chk("fl_bubble_we",    {31'd0, ex_reg_we_o}, 32'd0);
    drive(1'b0, 32'h400, 32'h0, 5'd8, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0);
    tick();
    chk("fl_no_held_valid", {31'd0, ex_valid_o},   32'd0);
    chk("gated_we",         {31'd0, ex_reg_we_o},  32'd0);
    chk("gated_load",       {31'd0, ex_is_load_o}, 32'd0);

    // x0 never forwards; PC operand overrides a matching rs1
    drive(1'b1, 32'h500, 32'h0, 5'd1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h504, 32'h0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
    tick();
    chk("x0_asel", {30'd0, ex_asel_o}, 32'd0);
    drive(1'b1, 32'h508, 32'h0, 5'd9, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);
    tick();
    chk("auipc_asel", {30'd0, ex_asel_o}, 32'd1);
    drive(1'b1, 32'h50C, 32'h0, 5'd3, 1'b0, 5'd11, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'h510, 32'h0, 5'd11, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0);
    chk("auipc_no_stall", {31'd0, id_ready_o}, 32'd1);
    tick();
    chk("auipc_after_lw_asel", {30'd0, ex_asel_o}, 32'd1);

    // Reset asserted during a load-use stall
    drive(1'b1, 32'h600, 32'h0, 5'd3, 1'b0, 5'd12, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'h604, 32'h0, 5'd12, 1'b0, 5'd13, 1'b1, 1'b0, 1'b0);
    chk("rst_pre_ready", {31'd0, id_ready_o}, 32'd0);
    #1;
    rst_n_i = 1'b0;
    #1;
    chk_reset_state("rst_mid");
    @(negedge clk_i);
    rst_n_i = 1'b1;
    tick();
    chk("rst_after_valid", {31'd0, ex_valid_o}, 32'd1);
    chk("rst_after_asel",  {30'd0, ex_asel_o},  32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
